// File: rtl/biu_cache_arbiter_if.sv
// Cache-side and BIU-side signal bundle for biu_cache_arbiter.
// slave = the arbiter's view; master = the view of the caches and BIU that surround it.
interface biu_cache_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
);
  logic              icache_req_vld_i;
  logic              icache_req_rdy_o;
  logic [ADDR_W-1:0] icache_req_addr_i;
  logic              icache_resp_vld_o;
  logic              icache_resp_ack_i;
  logic [LINE_W-1:0] icache_resp_rdata_o;
  logic              icache_resp_err_o;

  logic              dcache_req_vld_i;
  logic              dcache_req_rdy_o;
  logic              dcache_req_rd_i;
  logic [ADDR_W-1:0] dcache_req_addr_i;
  logic [LINE_W-1:0] dcache_req_wdata_i;
  logic              dcache_resp_vld_o;
  logic              dcache_resp_ack_i;
  logic [LINE_W-1:0] dcache_resp_rdata_o;
  logic              dcache_resp_err_o;

  logic              cache_req_vld_o;
  logic              cache_req_rdy_i;
  logic              cache_req_rd_o;
  logic [ADDR_W-1:0] cache_req_addr_o;
  logic [LINE_W-1:0] cache_req_wdata_o;
  logic              cache_resp_vld_i;
  logic              cache_resp_ack_o;
  logic [LINE_W-1:0] cache_resp_rdata_i;
  logic              cache_resp_err_i;

  modport slave (
    input  icache_req_vld_i, icache_req_addr_i, icache_resp_ack_i,
    input  dcache_req_vld_i, dcache_req_rd_i, dcache_req_addr_i, dcache_req_wdata_i, dcache_resp_ack_i,
    input  cache_req_rdy_i, cache_resp_vld_i, cache_resp_rdata_i, cache_resp_err_i,
    output icache_req_rdy_o, icache_resp_vld_o, icache_resp_rdata_o, icache_resp_err_o,
    output dcache_req_rdy_o, dcache_resp_vld_o, dcache_resp_rdata_o, dcache_resp_err_o,
    output cache_req_vld_o, cache_req_rd_o, cache_req_addr_o, cache_req_wdata_o, cache_resp_ack_o
  );

  modport master (
    output icache_req_vld_i, icache_req_addr_i, icache_resp_ack_i,
    output dcache_req_vld_i, dcache_req_rd_i, dcache_req_addr_i, dcache_req_wdata_i, dcache_resp_ack_i,
    output cache_req_rdy_i, cache_resp_vld_i, cache_resp_rdata_i, cache_resp_err_i,
    input  icache_req_rdy_o, icache_resp_vld_o, icache_resp_rdata_o, icache_resp_err_o,
    input  dcache_req_rdy_o, dcache_resp_vld_o, dcache_resp_rdata_o, dcache_resp_err_o,
    input  cache_req_vld_o, cache_req_rd_o, cache_req_addr_o, cache_req_wdata_o, cache_resp_ack_o
  );
endinterface

// File: rtl/biu_cache_arbiter.sv
// Round-robin arbiter merging I-cache refills and D-cache refills/writebacks onto the
// single BIU cache request/response channel, one transaction in flight at a time.
module biu_cache_arbiter #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  biu_cache_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESP} state_t;
  typedef enum logic {CL_I, CL_D} client_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

  state_t            state_q, state_d;
  client_t           last_grant_q, owner_q;
  logic              rd_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q, rdata_q;
  logic              gnt_i, gnt_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Handshake outputs are masked while rst is high so nothing is granted or
  // acknowledged in the reset cycle, even mid-transaction.
  always_comb begin
    state_d              = state_q;
    gnt_i                = 1'b0;
    gnt_d                = 1'b0;
    bus.cache_req_vld_o  = 1'b0;
    bus.cache_resp_ack_o = 1'b0;
    bus.icache_resp_vld_o = 1'b0;
    bus.dcache_resp_vld_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          gnt_d = bus.dcache_req_vld_i && (!bus.icache_req_vld_i || last_grant_q == CL_I);
          gnt_i = bus.icache_req_vld_i && !gnt_d;
        end
        if (gnt_i || gnt_d) state_d = ISSUE;
      end
      ISSUE: begin
        bus.cache_req_vld_o = !rst;
        if (bus.cache_req_rdy_i) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        bus.cache_resp_ack_o = !rst;
        if (bus.cache_resp_vld_i) state_d = RESP;
      end
      RESP: begin
        bus.icache_resp_vld_o = !rst && owner_q == CL_I;
        bus.dcache_resp_vld_o = !rst && owner_q == CL_D;
        if ((owner_q == CL_I) ? bus.icache_resp_ack_i : bus.dcache_resp_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= CL_I;
      owner_q      <= CL_I;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      if (gnt_i) begin
        owner_q      <= CL_I;
        last_grant_q <= CL_I;
        rd_q         <= 1'b1;
        addr_q       <= bus.icache_req_addr_i & LINE_MASK;
        wdata_q      <= '0;
      end else if (gnt_d) begin
        owner_q      <= CL_D;
        last_grant_q <= CL_D;
        rd_q         <= bus.dcache_req_rd_i;
        addr_q       <= bus.dcache_req_addr_i & LINE_MASK;
        wdata_q      <= bus.dcache_req_rd_i ? '0 : bus.dcache_req_wdata_i;
      end
      if (state_q == WAIT_RESP && bus.cache_resp_vld_i) begin
        rdata_q <= bus.cache_resp_rdata_i;
        err_q   <= bus.cache_resp_err_i;
      end
    end
  end

  assign bus.icache_req_rdy_o    = gnt_i;
  assign bus.dcache_req_rdy_o    = gnt_d;
  assign bus.cache_req_rd_o      = rd_q;
  assign bus.cache_req_addr_o    = addr_q;
  assign bus.cache_req_wdata_o   = wdata_q;
  assign bus.icache_resp_rdata_o = rdata_q;
  assign bus.icache_resp_err_o   = err_q;
  assign bus.dcache_resp_rdata_o = rdata_q;
  assign bus.dcache_resp_err_o   = err_q;
endmodule

// File: tb/tb_biu_cache_arbiter.sv
// Randomized self-checking bench for biu_cache_arbiter against a transaction-level
// model of the grant rule, the captured request and the routed response.
module tb_biu_cache_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  biu_cache_arbiter_if #(.ADDR_W(64), .LINE_W(512)) bus ();
  biu_cache_arbiter #(.ADDR_W(64), .LINE_W(512)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Pending client requests and the next BIU response, as the clients/BIU see them.
  logic [63:0]  i_addr, d_addr;
  logic         d_rd;
  logic [511:0] d_wd, biu_line;
  logic         biu_err;
  bit           model_last_d;   // last granted client was the D-cache
  bit           grant_log[$];   // 1 = D-cache granted

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic new_i();
    i_addr = {$urandom, $urandom};
    bus.icache_req_addr_i = i_addr;
  endtask

  task automatic new_d();
    d_addr = {$urandom, $urandom};
    d_rd = $urandom_range(0, 1);
    d_wd = rand_line();
    bus.dcache_req_addr_i = d_addr;
    bus.dcache_req_rd_i = d_rd;
    bus.dcache_req_wdata_i = d_wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.icache_req_vld_i = 0; bus.dcache_req_vld_i = 0;
    bus.icache_resp_ack_i = 0; bus.dcache_resp_ack_i = 0;
    bus.cache_req_rdy_i = 0; bus.cache_resp_vld_i = 0;
    bus.cache_resp_rdata_i = '0; bus.cache_resp_err_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    model_last_d = 0;
    biu_line = rand_line();
    biu_err = 0;
  endtask

  // One complete transaction. Entered and left at edge+2 of an IDLE cycle.
  task automatic arb_round(input bit iv, input bit dv, input int rdy_dly,
                           input int resp_dly, input int ack_dly, input bit keep);
    bit win_d, ive, dve, erd, rerr;
    logic [63:0] ea;
    logic [511:0] ew, line;
    if (iv) bus.icache_req_vld_i = 1;
    if (dv) bus.dcache_req_vld_i = 1;
    bus.icache_req_addr_i = i_addr;
    bus.dcache_req_addr_i = d_addr; bus.dcache_req_rd_i = d_rd; bus.dcache_req_wdata_i = d_wd;
    ive = bus.icache_req_vld_i; dve = bus.dcache_req_vld_i;
    win_d = dve && (!ive || !model_last_d);
    ea = (win_d ? d_addr : i_addr) & ~64'h3f;
    erd = win_d ? d_rd : 1'b1;
    ew = (win_d && !d_rd) ? d_wd : '0;
    line = biu_line; rerr = biu_err;
    #1;
    vectors++;
    if ({bus.icache_req_rdy_o, bus.dcache_req_rdy_o} !== {!win_d, win_d}) begin
      miscompares++;
      $display("FAIL grant: rdy i/d=%b%b expected %b%b", bus.icache_req_rdy_o, bus.dcache_req_rdy_o, !win_d, win_d);
    end
    @(posedge clk); #1;
    model_last_d = win_d;
    grant_log.push_back(win_d);
    if (win_d) begin new_d(); if (!keep) bus.dcache_req_vld_i = 0; end
    else begin new_i(); if (!keep) bus.icache_req_vld_i = 0; end
    #1;
    for (int c = 0; c <= rdy_dly; c++) begin
      vectors++;
      if ({bus.cache_req_vld_o, bus.cache_req_rd_o, bus.cache_req_addr_o} !== {1'b1, erd, ea}
          || bus.cache_req_wdata_o !== ew) begin
        miscompares++;
        $display("FAIL req_fields: vld=%b rd=%b addr=%h wdata=%h expected vld=1 rd=%b addr=%h wdata=%h",
                 bus.cache_req_vld_o, bus.cache_req_rd_o, bus.cache_req_addr_o, bus.cache_req_wdata_o, erd, ea, ew);
      end
      vectors++;
      if ({bus.icache_req_rdy_o, bus.dcache_req_rdy_o, bus.cache_resp_ack_o,
           bus.icache_resp_vld_o, bus.dcache_resp_vld_o} !== 5'b0) begin
        miscompares++;
        $display("FAIL issue_quiet: rdy i/d, ack, resp_vld i/d = %b%b%b%b%b expected 00000",
                 bus.icache_req_rdy_o, bus.dcache_req_rdy_o, bus.cache_resp_ack_o, bus.icache_resp_vld_o, bus.dcache_resp_vld_o);
      end
      bus.cache_req_rdy_i = (c == rdy_dly);
      @(posedge clk); #1; bus.cache_req_rdy_i = 0; #1;
    end
    for (int c = 0; c <= resp_dly; c++) begin
      vectors++;
      if ({bus.cache_resp_ack_o, bus.cache_req_vld_o, bus.icache_req_rdy_o, bus.dcache_req_rdy_o,
           bus.icache_resp_vld_o, bus.dcache_resp_vld_o} !== 6'b100000) begin
        miscompares++;
        $display("FAIL wait_resp: ack, req_vld, rdy i/d, resp_vld i/d = %b%b%b%b%b%b expected 100000",
                 bus.cache_resp_ack_o, bus.cache_req_vld_o, bus.icache_req_rdy_o, bus.dcache_req_rdy_o,
                 bus.icache_resp_vld_o, bus.dcache_resp_vld_o);
      end
      bus.cache_resp_vld_i = (c == resp_dly);
      bus.cache_resp_rdata_i = (c == resp_dly) ? line : rand_line();
      bus.cache_resp_err_i = (c == resp_dly) ? rerr : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.cache_resp_vld_i = 0; bus.cache_resp_rdata_i = rand_line(); bus.cache_resp_err_i = 1'($urandom_range(0, 1));
      #1;
    end
    for (int c = 0; c <= ack_dly; c++) begin
      vectors++;
      if ({bus.icache_resp_vld_o, bus.dcache_resp_vld_o} !== {!win_d, win_d}
          || (win_d ? bus.dcache_resp_rdata_o : bus.icache_resp_rdata_o) !== line
          || (win_d ? bus.dcache_resp_err_o : bus.icache_resp_err_o) !== rerr) begin
        miscompares++;
        $display("FAIL resp_route: resp_vld i/d=%b%b err=%b rdata=%h expected %b%b err=%b rdata=%h",
                 bus.icache_resp_vld_o, bus.dcache_resp_vld_o,
                 win_d ? bus.dcache_resp_err_o : bus.icache_resp_err_o,
                 win_d ? bus.dcache_resp_rdata_o : bus.icache_resp_rdata_o, !win_d, win_d, rerr, line);
      end
      vectors++;
      if ({bus.icache_req_rdy_o, bus.dcache_req_rdy_o, bus.cache_resp_ack_o, bus.cache_req_vld_o} !== 4'b0) begin
        miscompares++;
        $display("FAIL resp_quiet: rdy i/d, ack, req_vld = %b%b%b%b expected 0000",
                 bus.icache_req_rdy_o, bus.dcache_req_rdy_o, bus.cache_resp_ack_o, bus.cache_req_vld_o);
      end
      // The non-owner's ack is noise and must not end the transaction.
      if (win_d) begin bus.dcache_resp_ack_i = (c == ack_dly); bus.icache_resp_ack_i = 1'($urandom_range(0, 1)); end
      else begin bus.icache_resp_ack_i = (c == ack_dly); bus.dcache_resp_ack_i = 1'($urandom_range(0, 1)); end
      @(posedge clk); #1; bus.icache_resp_ack_i = 0; bus.dcache_resp_ack_i = 0; #1;
    end
  endtask

  task automatic test_reset();
    bus.icache_req_vld_i = 1; bus.dcache_req_vld_i = 1;
    rst = 1'b1;
    @(posedge clk); #2;
    vectors++;
    if ({bus.icache_req_rdy_o, bus.dcache_req_rdy_o, bus.cache_req_vld_o, bus.cache_resp_ack_o,
         bus.icache_resp_vld_o, bus.dcache_resp_vld_o, bus.cache_req_rd_o, bus.icache_resp_err_o} !== 8'b0
        || bus.cache_req_addr_o !== 64'h0 || bus.cache_req_wdata_o !== '0 || bus.icache_resp_rdata_o !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b%b req_vld=%b ack=%b resp_vld=%b%b addr=%h expected all zero",
               bus.icache_req_rdy_o, bus.dcache_req_rdy_o, bus.cache_req_vld_o, bus.cache_resp_ack_o,
               bus.icache_resp_vld_o, bus.dcache_resp_vld_o, bus.cache_req_addr_o);
    end
    do_reset();
  endtask

  task automatic test_single_icache();
    do_reset();
    i_addr = 64'h0000_0000_8000_0047;
    biu_line = {64{8'hA5}};
    biu_err = 0;
    arb_round(1, 0, 0, 1, 0, 0);
  endtask

  task automatic test_tie_from_reset();
    do_reset();
    grant_log.delete();
    new_i(); new_d();
    arb_round(1, 1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    biu_line = rand_line();
    arb_round(0, 0, 0, 0, 0, 0);
    vectors++;
    if (grant_log.size() != 2 || grant_log[0] !== 1'b1 || grant_log[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_order: %0d grants first=%b expected D then I", grant_log.size(), grant_log[0]);
    end
  endtask

  task automatic test_saturation();
    bit exp_d;
    do_reset();
    grant_log.delete();
    new_i(); new_d();
    for (int n = 0; n < 6; n++) begin
      biu_line = rand_line(); biu_err = 1'($urandom_range(0, 1));
      arb_round(1, 1, $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 1), 1);
    end
    bus.icache_req_vld_i = 0; bus.dcache_req_vld_i = 0;
    for (int n = 0; n < 6; n++) begin
      exp_d = (n % 2) == 0;
      vectors++;
      if (grant_log[n] !== exp_d) begin
        miscompares++;
        $display("FAIL alternation[%0d]: granted_d=%b expected %b", n, grant_log[n], exp_d);
      end
    end
  endtask

  task automatic test_writeback_err();
    new_d();
    d_rd = 0;
    d_wd = {8{64'h1122334455667788}};
    biu_line = rand_line();
    biu_err = 1;
    arb_round(0, 1, 3, 2, 0, 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    new_i(); new_d();
    arb_round(1, 1, 0, 1, 5, 0);
    biu_line = rand_line();
    arb_round(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_reset_wait_resp();
    do_reset();
    new_d();
    bus.dcache_req_vld_i = 1;
    @(posedge clk); #1;
    bus.dcache_req_vld_i = 0;
    bus.cache_req_rdy_i = 1;
    @(posedge clk); #1;
    bus.cache_req_rdy_i = 0;
    #1;
    vectors++;
    if (bus.cache_resp_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_setup: ack=%b expected 1", bus.cache_resp_ack_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cache_resp_vld_i = 1; bus.cache_resp_rdata_i = rand_line(); bus.cache_resp_err_i = 1;
    #1;
    vectors++;
    if ({bus.cache_resp_ack_o, bus.cache_req_vld_o, bus.icache_req_rdy_o, bus.dcache_req_rdy_o,
         bus.icache_resp_vld_o, bus.dcache_resp_vld_o, bus.dcache_resp_err_o} !== 7'b0
        || bus.cache_req_addr_o !== 64'h0 || bus.cache_req_wdata_o !== '0 || bus.dcache_resp_rdata_o !== '0) begin
      miscompares++;
      $display("FAIL reset_midflight: ack=%b req_vld=%b resp_vld=%b%b err=%b addr=%h expected all zero",
               bus.cache_resp_ack_o, bus.cache_req_vld_o, bus.icache_resp_vld_o, bus.dcache_resp_vld_o,
               bus.dcache_resp_err_o, bus.cache_req_addr_o);
    end
    @(posedge clk); #1;
    bus.cache_resp_vld_i = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({bus.icache_resp_vld_o, bus.dcache_resp_vld_o, bus.cache_resp_ack_o} !== 3'b0) begin
        miscompares++;
        $display("FAIL stale_resp[%0d]: resp_vld=%b%b ack=%b expected 000",
                 c, bus.icache_resp_vld_o, bus.dcache_resp_vld_o, bus.cache_resp_ack_o);
      end
      @(posedge clk); #1;
    end
    #1;
    model_last_d = 0;
    new_i(); new_d();
    biu_line = rand_line(); biu_err = 0;
    arb_round(1, 1, 1, 1, 1, 0);
    biu_line = rand_line();
    arb_round(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit iv, dv;
    do_reset();
    new_i(); new_d();
    for (int n = 0; n < 24; n++) begin
      iv = 1'($urandom_range(0, 1));
      dv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
      biu_line = rand_line(); biu_err = 1'($urandom_range(0, 1));
      arb_round(iv, dv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end
    bus.icache_req_vld_i = 0; bus.dcache_req_vld_i = 0;
  endtask

  initial begin
    i_addr = '0; d_addr = '0; d_rd = 1; d_wd = '0; biu_line = '0; biu_err = 0;
    bus.icache_req_addr_i = '0; bus.dcache_req_addr_i = '0;
    bus.dcache_req_rd_i = 1; bus.dcache_req_wdata_i = '0;
    do_reset();
    test_reset();
    test_single_icache();
    test_tie_from_reset();
    test_saturation();
    test_writeback_err();
    test_backpressure();
    test_reset_wait_resp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
